// File: rtl/spi_master_sckgen.sv
// spi_master_sckgen: SPI master serial-clock generator.
// Produces a registered SCK burst of num_clks full cycles with a programmable
// half-period, plus one-cycle edge strobes (rise/fall) and CPOL/CPHA-mapped
// data strobes (sample/shift) that a shift register can use directly.
//
// Handshake: start is a single-cycle request, honoured only in IDLE; num_clks
// is sampled in that same cycle. stop aborts a running burst on the next clock
// edge. busy marks RUN; done pulses for one cycle after a burst that completed
// normally. There is no back-pressure.
//
// Strobe timing: every strobe is asserted combinationally in the clk cycle
// *before* spi_clk changes, so a consumer registering on the same clk edge
// acts together with the SCK transition.
module spi_master_sckgen #(
    parameter int DIV_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             cfg_div_valid,
    input  logic             cfg_cpol,
    input  logic             cfg_cpha,
    input  logic             start,
    input  logic [CNT_W-1:0] num_clks,
    input  logic             stop,
    output logic             busy,
    output logic             done,
    output logic             spi_clk,
    output logic             spi_rise,
    output logic             spi_fall,
    output logic             spi_sample,
    output logic             spi_shift,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [DIV_W-1:0] DIV_ONE  = 1;
    localparam logic [CNT_W:0]   EDGE_ONE = 1;

    state_t           r_state;
    logic [DIV_W-1:0] r_div;        // half-period target
    logic [DIV_W-1:0] r_cnt;        // half-period counter
    logic [CNT_W:0]   r_edges_left; // SCK edges still to generate (2*N max)
    logic             r_cpol;       // polarity latched at start
    logic             r_cpha;       // phase latched at start
    logic             r_spi_clk;
    logic             r_busy;
    logic             r_done;

    // Terminal count uses >= so that lowering the target mid-burst ends the
    // current half-period at once instead of wrapping the counter.
    logic w_tc;
    logic w_edge;
    logic w_leading;
    logic w_last;

    assign w_tc      = (r_state == ST_RUN) && (r_cnt >= r_div);
    assign w_edge    = w_tc && !stop;
    // A leading edge moves SCK away from its idle level.
    assign w_leading = (r_spi_clk == r_cpol);
    assign w_last    = (r_edges_left == EDGE_ONE);

    assign spi_rise   = w_edge && !r_spi_clk;
    assign spi_fall   = w_edge &&  r_spi_clk;
    // CPHA=0 samples on leading edges and shifts on trailing edges; the final
    // trailing edge carries no shift because no further bit follows.
    // CPHA=1 shifts on leading edges and samples on trailing edges.
    assign spi_sample = w_edge && (r_cpha ? !w_leading : w_leading);
    assign spi_shift  = w_edge && (r_cpha ? w_leading : (!w_leading && !w_last));

    assign busy      = r_busy;
    assign done      = r_done;
    assign spi_clk   = r_spi_clk;
    assign dbg_state = r_state;

    // Divider target register; reloadable at any time, including mid-burst.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_div <= '0;
        end else if (cfg_div_valid) begin
            r_div <= cfg_div;
        end
    end

    // Burst FSM with half-period counter, edge counter and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_edges_left <= '0;
            r_cpol       <= 1'b0;
            r_cpha       <= 1'b0;
            r_spi_clk    <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt     <= '0;
                    r_spi_clk <= cfg_cpol;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b0;
                    if (start) begin
                        if (num_clks != '0) begin
                            r_edges_left <= {num_clks, 1'b0};
                            r_cpol       <= cfg_cpol;
                            r_cpha       <= cfg_cpha;
                            r_busy       <= 1'b1;
                            r_state      <= ST_RUN;
                        end else begin
                            // Empty burst: report completion without any edge.
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end
                end

                ST_RUN: begin
                    if (stop) begin
                        r_cnt     <= '0;
                        r_spi_clk <= cfg_cpol;
                        r_busy    <= 1'b0;
                        r_state   <= ST_IDLE;
                    end else if (w_tc) begin
                        r_cnt        <= '0;
                        r_spi_clk    <= !r_spi_clk;
                        r_edges_left <= r_edges_left - EDGE_ONE;
                        if (w_last) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end else begin
                        r_cnt <= r_cnt + DIV_ONE;
                    end
                end

                ST_DONE: begin
                    // SCK already sits at the latched idle level after the
                    // final trailing edge; hold it for this one cycle.
                    r_cnt   <= '0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_sckgen.sv
// Directed bench for spi_master_sckgen. Cycle c is the clk period that begins
// at the c-th rising edge after a burst's start is driven; inputs change 1ns
// after a rising edge and outputs are checked on the falling edge.
// Expected per-cycle waveforms are hand-written bit masks (bit c = cycle c).
module tb_spi_master_sckgen;

    localparam int DIV_W = 8;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic [DIV_W-1:0] cfg_div = '0;
    logic             cfg_div_valid = 1'b0;
    logic             cfg_cpol = 1'b0;
    logic             cfg_cpha = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] num_clks = '0;
    logic             stop = 1'b0;
    logic             busy, done, spi_clk, spi_rise, spi_fall, spi_sample, spi_shift;
    logic [1:0]       dbg_state;

    int checks = 0;
    int errors = 0;

    spi_master_sckgen #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .cfg_div       (cfg_div),
        .cfg_div_valid (cfg_div_valid),
        .cfg_cpol      (cfg_cpol),
        .cfg_cpha      (cfg_cpha),
        .start         (start),
        .num_clks      (num_clks),
        .stop          (stop),
        .busy          (busy),
        .done          (done),
        .spi_clk       (spi_clk),
        .spi_rise      (spi_rise),
        .spi_fall      (spi_fall),
        .spi_sample    (spi_sample),
        .spi_shift     (spi_shift),
        .dbg_state     (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int c, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, c, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_div(input logic [DIV_W-1:0] v);
        cfg_div       = v;
        cfg_div_valid = 1'b1;
        step();
        cfg_div_valid = 1'b0;
    endtask

    // Runs cycles 0..ncyc-1 of a burst whose start/cfg were driven by the caller
    // for cycle 0. stop / cfg_div_valid are pulsed in the named cycle (-1: never).
    task automatic run_scn(input string nm, input int ncyc, input int stop_cyc, input int load_cyc,
                           input logic [31:0] rise_m, input logic [31:0] fall_m,
                           input logic [31:0] samp_m, input logic [31:0] shift_m,
                           input logic [31:0] busy_m, input logic [31:0] done_m,
                           input logic [31:0] clk_m);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            chk({nm, " rise"},   c, {1'b0, spi_rise},   {1'b0, rise_m[c]});
            chk({nm, " fall"},   c, {1'b0, spi_fall},   {1'b0, fall_m[c]});
            chk({nm, " sample"}, c, {1'b0, spi_sample}, {1'b0, samp_m[c]});
            chk({nm, " shift"},  c, {1'b0, spi_shift},  {1'b0, shift_m[c]});
            chk({nm, " busy"},   c, {1'b0, busy},       {1'b0, busy_m[c]});
            chk({nm, " done"},   c, {1'b0, done},       {1'b0, done_m[c]});
            chk({nm, " spi_clk"},c, {1'b0, spi_clk},    {1'b0, clk_m[c]});
            step();
            start         = 1'b0;
            stop          = (c + 1 == stop_cyc);
            cfg_div_valid = (c + 1 == load_cyc);
        end
        stop          = 1'b0;
        cfg_div_valid = 1'b0;
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, " busy"},    0, {1'b0, busy},       2'd0);
        chk({nm, " done"},    0, {1'b0, done},       2'd0);
        chk({nm, " spi_clk"}, 0, {1'b0, spi_clk},    2'd0);
        chk({nm, " strobes"}, 0, {1'b0, spi_rise | spi_fall | spi_sample | spi_shift}, 2'd0);
        chk({nm, " state"},   0, dbg_state,          2'd0);
    endtask

    initial begin
        // Reset state
        #1;
        chk_reset_vals("reset");
        step();
        step();
        rstn = 1'b1;
        step();

        // Mode 0, div=1, N=2
        cfg_cpol = 1'b0; cfg_cpha = 1'b0;
        load_div(8'd1);
        num_clks = 16'd2; start = 1'b1;
        run_scn("m0d1n2", 11, -1, -1, 32'h44, 32'h110, 32'h44, 32'h10, 32'h1FE, 32'h200, 32'h198);

        // Mode 3 (cpol=1, cpha=1), div=0, N=3
        cfg_cpol = 1'b1; cfg_cpha = 1'b1;
        load_div(8'd0);
        num_clks = 16'd3; start = 1'b1;
        run_scn("m3d0n3", 9, -1, -1, 32'h54, 32'h2A, 32'h54, 32'h2A, 32'h7E, 32'h80, 32'h1AB);

        // Empty burst
        cfg_cpol = 1'b0; cfg_cpha = 1'b0;
        step();
        num_clks = 16'd0; start = 1'b1;
        run_scn("n0", 4, -1, -1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h2, 32'h0);

        // Stop coinciding with edge 2
        load_div(8'd3);
        num_clks = 16'd4; start = 1'b1;
        run_scn("stop", 11, 8, -1, 32'h10, 32'h0, 32'h10, 32'h0, 32'h1FE, 32'h0, 32'h1E0);

        // Divider lowered to 0 mid-burst (load pulsed in cycle 2, active in cycle 3)
        load_div(8'd3);
        cfg_div = 8'd0;
        num_clks = 16'd4; start = 1'b1;
        run_scn("divlow", 13, -1, 2, 32'h2A8, 32'h550, 32'h2A8, 32'h150, 32'h7FE, 32'h800, 32'h550);

        // Reset asserted in cycle 5 of a burst
        load_div(8'd1);
        num_clks = 16'd2; start = 1'b1;
        run_scn("prerst", 5, -1, -1, 32'h44, 32'h110, 32'h44, 32'h10, 32'h1FE, 32'h200, 32'h198);
        rstn = 1'b0;
        #1;
        chk_reset_vals("midrst");
        step();
        chk_reset_vals("midrst_hold");
        step();
        rstn = 1'b1;
        step();
        load_div(8'd1);
        num_clks = 16'd2; start = 1'b1;
        run_scn("postrst", 11, -1, -1, 32'h44, 32'h110, 32'h44, 32'h10, 32'h1FE, 32'h200, 32'h198);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
